// File: rtl/bnn_mon_pkg.sv
// rtl/bnn_mon_pkg.sv - shared types and constants for the BNN result monitor
package bnn_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_t;

    localparam logic [3:0] IDX_INVALID = 4'hF;
    localparam int         NUM_PAGES   = 3;

    // Live LED view while classifying: match, invalid, spare, predicted digit.
    function automatic logic [7:0] live_led(input logic match,
                                            input logic invalid,
                                            input logic [3:0] y_idx);
        return {match, invalid, 2'b00, y_idx};
    endfunction

endpackage

// File: rtl/onehot10_decode.sv
// rtl/onehot10_decode.sv - 10-bit one-hot to digit index decode, invalid unless exactly one bit set
module onehot10_decode
    import bnn_mon_pkg::*;
(
    input  logic [9:0] onehot,
    output logic [3:0] idx,
    output logic       valid
);

    logic [3:0] ones;
    logic [3:0] pos;

    always_comb begin
        ones = 4'd0;
        pos  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (onehot[i]) begin
                ones = ones + 4'd1;
                pos  = 4'(i);
            end
        end
        valid = (ones == 4'd1);
        idx   = valid ? pos : IDX_INVALID;
    end

endmodule

// File: rtl/bnn_result_monitor.sv
// rtl/bnn_result_monitor.sv - scores BNN predictions against targets and pages totals onto LEDs
module bnn_result_monitor
    import bnn_mon_pkg::*;
#(
    parameter int SAMPLES  = 100,
    parameter int CNT_W    = 16,
    parameter int DISP_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       vec_y,
    input  logic [9:0]       vec_t,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             start,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic             done,
    output logic [7:0]       led
);

    localparam int PRESC_W = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

    mon_state_t         state;
    logic [9:0]         y_q;
    logic [9:0]         t_q;
    logic               last_match;
    logic               last_invalid;
    logic [3:0]         last_y_idx;
    logic [1:0]         page;
    logic [PRESC_W-1:0] presc;

    logic [3:0]         y_idx;
    logic [3:0]         t_idx;
    logic               y_ok;
    logic               t_ok;
    logic               match;
    logic               invalid;
    logic [CNT_W-1:0]   correct_n;
    logic [CNT_W-1:0]   total_n;
    logic [CNT_W-1:0]   invalid_n;
    logic [1:0]         page_n;

    onehot10_decode u_dec_y (.onehot(y_q), .idx(y_idx), .valid(y_ok));
    onehot10_decode u_dec_t (.onehot(t_q), .idx(t_idx), .valid(t_ok));

    always_comb begin
        invalid   = !(y_ok && t_ok);
        match     = y_ok && t_ok && (y_idx == t_idx);
        total_n   = total_cnt + CNT_W'(1);
        correct_n = correct_cnt + (match ? CNT_W'(1) : CNT_W'(0));
        invalid_n = invalid_cnt + (invalid ? CNT_W'(1) : CNT_W'(0));
        page_n    = (page == 2'(NUM_PAGES - 1)) ? 2'd0 : page + 2'd1;
    end

    function automatic logic [7:0] page_led(input logic [1:0] p,
                                            input logic [CNT_W-1:0] c,
                                            input logic [CNT_W-1:0] t,
                                            input logic [CNT_W-1:0] inv);
        case (p)
            2'd0:    return c[7:0];
            2'd1:    return t[7:0];
            default: return inv[7:0];
        endcase
    endfunction

    // Every output is a register; led is loaded with the view matching the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            vec_ready    <= 1'b1;
            done         <= 1'b0;
            led          <= 8'h00;
            correct_cnt  <= '0;
            total_cnt    <= '0;
            invalid_cnt  <= '0;
            y_q          <= '0;
            t_q          <= '0;
            last_match   <= 1'b0;
            last_invalid <= 1'b0;
            last_y_idx   <= 4'd0;
            page         <= 2'd0;
            presc        <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (vec_valid) begin
                        y_q       <= vec_y;
                        t_q       <= vec_t;
                        state     <= ST_CHECK;
                        vec_ready <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    correct_cnt  <= correct_n;
                    total_cnt    <= total_n;
                    invalid_cnt  <= invalid_n;
                    last_match   <= match;
                    last_invalid <= invalid;
                    last_y_idx   <= y_idx;
                    if (total_n == CNT_W'(SAMPLES)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        page  <= 2'd0;
                        presc <= '0;
                        led   <= correct_n[7:0];
                    end else begin
                        state     <= ST_RUN;
                        vec_ready <= 1'b1;
                        led       <= live_led(match, invalid, y_idx);
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        correct_cnt <= '0;
                        total_cnt   <= '0;
                        invalid_cnt <= '0;
                        page        <= 2'd0;
                        presc       <= '0;
                        state       <= ST_RUN;
                        vec_ready   <= 1'b1;
                        done        <= 1'b0;
                        led         <= live_led(last_match, last_invalid, last_y_idx);
                    end else if (presc == PRESC_W'(DISP_DIV - 1)) begin
                        presc <= '0;
                        page  <= page_n;
                        led   <= page_led(page_n, correct_cnt, total_cnt, invalid_cnt);
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    vec_ready <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_result_monitor.sv
// tb/tb_bnn_result_monitor.sv - directed vector bench for bnn_result_monitor (SAMPLES=4, DISP_DIV=3)
module tb_bnn_result_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [9:0]       vec_y;
    logic [9:0]       vec_t;
    logic             vec_valid;
    logic             vec_ready;
    logic             start;
    logic [CNT_W-1:0] correct_cnt;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] invalid_cnt;
    logic             done;
    logic [7:0]       led;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0] y;
        logic [9:0] t;
        int         correct;
        int         total;
        int         invalid;
        logic [7:0] led;
        logic       done;
    } vec_rec_t;

    vec_rec_t tbl[4];

    bnn_result_monitor #(.SAMPLES(4), .CNT_W(CNT_W), .DISP_DIV(3)) dut (
        .clk(clk), .rst(rst), .vec_y(vec_y), .vec_t(vec_t),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .start(start),
        .correct_cnt(correct_cnt), .total_cnt(total_cnt), .invalid_cnt(invalid_cnt),
        .done(done), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string name, input int c, input int t, input int inv);
        chk({name, ".correct"}, int'(correct_cnt), c);
        chk({name, ".total"}, int'(total_cnt), t);
        chk({name, ".invalid"}, int'(invalid_cnt), inv);
    endtask

    // Present one result, wait (bounded) for the handshake, then release valid.
    task automatic send(input logic [9:0] y, input logic [9:0] t);
        int n = 0;
        vec_y     = y;
        vec_t     = t;
        vec_valid = 1'b1;
        while (!vec_ready && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) chk("ready_timeout", 0, 1);
        tick();
        vec_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{10'h001, 10'h001, 1, 1, 0, 8'h80, 1'b0};
        tbl[1] = '{10'h002, 10'h004, 1, 2, 0, 8'h01, 1'b0};
        tbl[2] = '{10'h003, 10'h003, 1, 3, 1, 8'h4F, 1'b0};
        tbl[3] = '{10'h200, 10'h200, 2, 4, 1, 8'h02, 1'b1};

        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_y = '0; vec_t = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_cnts("reset", 0, 0, 0);
        chk("reset.ready", int'(vec_ready), 1);
        chk("reset.done", int'(done), 0);
        chk("reset.led", int'(led), 0);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].y, tbl[i].t);
            tick();
            chk_cnts($sformatf("row%0d", i), tbl[i].correct, tbl[i].total, tbl[i].invalid);
            chk($sformatf("row%0d.led", i), int'(led), int'(tbl[i].led));
            chk($sformatf("row%0d.done", i), int'(done), int'(tbl[i].done));
        end

        // Page cycling in DONE while a result is offered and must be ignored.
        vec_y = 10'h004; vec_t = 10'h004; vec_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_led;
            case ((i / 3) % 3)
                0:       exp_led = 8'h02;
                1:       exp_led = 8'h04;
                default: exp_led = 8'h01;
            endcase
            chk($sformatf("page_cyc%0d", i), int'(led), int'(exp_led));
            if (i < 9) tick();
        end
        chk("done_ignore_valid.total", int'(total_cnt), 4);

        // start together with vec_valid: clears, that valid not taken, next one is.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cnts("restart", 0, 0, 0);
        chk("restart.done", int'(done), 0);
        chk("restart.ready", int'(vec_ready), 1);
        tick();
        chk("held_accept.ready", int'(vec_ready), 0);
        chk("held_accept.total", int'(total_cnt), 0);
        tick();
        chk("held.total1", int'(total_cnt), 1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            tick();
            chk($sformatf("held.total%0d", k), int'(total_cnt), k);
        end
        vec_valid = 1'b0;
        chk_cnts("held_end", 4, 4, 0);
        chk("held_end.done", int'(done), 1);
        chk("held_end.led", int'(led), 8'h04);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cnts("restart2", 0, 0, 0);
        chk("restart2.led", int'(led), 8'h82);

        // start in RUN is ignored; valid held through CHECK counts only once.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start.ready", int'(vec_ready), 1);
        chk("run_start.done", int'(done), 0);
        vec_y = 10'h001; vec_t = 10'h001; vec_valid = 1'b1;
        tick();
        tick();
        vec_valid = 1'b0;
        tick();
        chk("check_valid.total", int'(total_cnt), 1);
        chk("check_valid.ready", int'(vec_ready), 1);

        // Reset during CHECK of the third result discards it.
        send(10'h002, 10'h002);
        tick();
        chk("pre_abort.total", int'(total_cnt), 2);
        send(10'h008, 10'h008);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnts("abort", 0, 0, 0);
        chk("abort.led", int'(led), 0);
        chk("abort.ready", int'(vec_ready), 1);
        tick();
        chk("abort_after.total", int'(total_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

endmodule
